dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Load/store initiator driving the byte-organised data RAM (8-bit cells, synchronous write, registered 1-cycle read) from the core's 16-bit load/store path. Accepts one request at a time through a valid/ready handshake. Splits each 16-bit word access into two little-endian byte accesses and sequences the RAM's read latency. Returns a one-cycle response pulse with the assembled read data.

## Interface
- `ADDR_WIDTH`, 16: byte address width. Addresses wrap modulo 2^ADDR_WIDTH.
- `DWIDTH`, 16: core data width. Fixed at 16: two bytes per word.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle; the request is accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 1: 0 = word (2 bytes), 1 = byte. Honoured only with `DMEM_CTRL_BYTE_ACCESS_EN` defined.
- `req_addr` in ADDR_WIDTH: byte address A.
- `req_wdata` in DWIDTH: store data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DWIDTH: load result. Valid with `rsp_valid` on loads.
- `ram_addr` out ADDR_WIDTH: RAM address.
- `ram_din` out 8: RAM write byte.
- `ram_we` out 1: RAM write enable.
- `ram_dout` in 8: RAM registered read data. Undefined/high-Z in cycles following a write; never sampled then.

## Operation
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_LAST, RESP.
- `req_ready` = (state == IDLE). No other state accepts requests.
- On accept, latch `req_we`, `req_size`, `req_addr`, `req_wdata`.
- Word store: IDLE → WR_LO (addr A, din wdata[7:0], we 1) → WR_HI (addr A+1, din wdata[15:8], we 1) → RESP → IDLE.
- Word load: IDLE → RD_LO (addr A, we 0) → RD_HI (addr A+1, we 0; capture `ram_dout` = mem[A] into low byte) → RD_LAST (capture `ram_dout` = mem[A+1] into high byte) → RESP → IDLE.
- Byte store: IDLE → WR_HI with addr A, din wdata[7:0] → RESP.
- Byte load: IDLE → RD_HI with addr A → RD_LAST (capture low byte, high byte = 0) → RESP.
- Endianness is little: mem[A] = bits 7:0, mem[A+1] = bits 15:8.
- Address arithmetic: A+1 is computed in ADDR_WIDTH bits. A = 0xFFFF gives a high byte at 0x0000.
- Odd addresses are legal. There is no alignment restriction.
- `rsp_rdata` updates only on load completion and holds until the next load completes. Stores leave it unchanged.
- `ram_we` is high only in WR_LO/WR_HI. `ram_addr`/`ram_din` hold their last values elsewhere.
- Reset mid-operation aborts immediately:
  - `ram_we` drops asynchronously.
  - A completed low-byte write stays in RAM. No response is issued.

## Timing
- Reset values:
  - state IDLE, so `req_ready` = 1.
  - `rsp_valid` 0, `rsp_rdata` 0.
  - `ram_addr` 0, `ram_din` 0, `ram_we` 0.
- All outputs except `req_ready` are registered. `req_ready` is decoded from the state register.
- Latency, counted from the accept edge (cycle 0) to `rsp_valid` high:
  - Word store: cycle 3.
  - Word load: cycle 4.
  - Byte store: cycle 2.
  - Byte load: cycle 3.
- `rsp_valid` is high for exactly one cycle. There is no backpressure on the response.
- The next request can be accepted in the cycle after RESP.
- `req_valid` held high while `req_ready` is low has no effect. Inputs are sampled only at accept.
- Back-to-back throughput: word store every 4 cycles, word load every 5.

## Configuration
- `DMEM_CTRL_BYTE_ACCESS_EN` defined:
  - `req_size` = 1 selects a single-byte access.
  - Byte loads zero-extend to 16 bits.
- Not defined:
  - `req_size` is ignored. Every access is a word access.
  - The byte-path state transitions are compiled out.

## Test plan
- Reset, then word store A=0x0010, wdata=0xBEEF → RAM cycle 1 writes 0xEF@0x0010, cycle 2 writes 0xBE@0x0011, `rsp_valid` at cycle 3.
- Word load A=0x0010 after the store above → `rsp_valid` at cycle 4 with `rsp_rdata` = 0xBEEF. `ram_we` stays 0 throughout.
- Wrap: word store A=0xFFFF, wdata=0x1234 → 0x34@0xFFFF, 0x12@0x0000. Word load A=0xFFFF returns 0x1234.
- Byte access with `DMEM_CTRL_BYTE_ACCESS_EN`: byte store A=0x0021, wdata=0xAA55 → only 0x55@0x0021, `rsp_valid` at cycle 2. Byte load A=0x0021 returns 0x0055 at cycle 3. Without the macro, the same requests perform word accesses.
- Handshake: hold `req_valid` high with changing `req_addr` during a load → only the first request is accepted. The next accept occurs the cycle after `rsp_valid`.
- Reset asserted in WR_HI of a word store to 0x0040 (wdata 0xCAFE) → `ram_we` drops immediately and no `rsp_valid`. 0xFE@0x0040 persists, 0x0041 is unchanged, and `req_ready` = 1 after release.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Core load/store handshake plus byte-wide RAM port for dmem_ctrl.
// slave = controller side, master = core/RAM side.
interface dmem_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DWIDTH     = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic                  req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DWIDTH-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DWIDTH-1:0]     rsp_rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_din;
  logic                  ram_we;
  logic [7:0]            ram_dout;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_din, ram_we
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/dmem_ctrl.sv
// 16-bit load/store to byte RAM sequencer, little-endian, one request at a time.
// Define DMEM_CTRL_BYTE_ACCESS_EN to honour req_size (single-byte accesses).
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DWIDTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_LAST, RESP} state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0]     wdata_q, wdata_d;
  logic [DWIDTH-1:0]     rdata_q, rdata_d;
  logic [7:0]            lo_q, lo_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            din_q, din_d;
  logic                  ram_we_q, ram_we_d;
  logic                  rsp_valid_q, rsp_valid_d;

`ifdef DMEM_CTRL_BYTE_ACCESS_EN
  logic                  byte_q, byte_d;
`else
  logic                  unused_size;
  assign unused_size = bus.req_size;
`endif

  // RAM-facing outputs are computed one state ahead so they are registered
  // yet line up with the state they belong to.
  always_comb begin
    state_d     = state;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    lo_d        = lo_q;
    ram_addr_d  = ram_addr_q;
    din_d       = din_q;
    ram_we_d    = 1'b0;
    rsp_valid_d = 1'b0;
`ifdef DMEM_CTRL_BYTE_ACCESS_EN
    byte_d      = byte_q;
`endif
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          ram_addr_d = bus.req_addr;
          if (bus.req_we) begin
            din_d    = bus.req_wdata[7:0];
            ram_we_d = 1'b1;
            state_d  = WR_LO;
          end else begin
            state_d  = RD_LO;
          end
`ifdef DMEM_CTRL_BYTE_ACCESS_EN
          byte_d = bus.req_size;
          if (bus.req_size) state_d = bus.req_we ? WR_HI : RD_HI;
`endif
        end
      end
      WR_LO: begin
        ram_addr_d = addr_q + 1'b1;
        din_d      = wdata_q[DWIDTH-1:8];
        ram_we_d   = 1'b1;
        state_d    = WR_HI;
      end
      WR_HI: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RD_LO: begin
        ram_addr_d = addr_q + 1'b1;
        state_d    = RD_HI;
      end
      RD_HI: begin
        lo_d    = bus.ram_dout;
        state_d = RD_LAST;
      end
      RD_LAST: begin
        rdata_d = {bus.ram_dout, lo_q};
`ifdef DMEM_CTRL_BYTE_ACCESS_EN
        if (byte_q) rdata_d = {8'h00, bus.ram_dout};
`endif
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      lo_q        <= '0;
      ram_addr_q  <= '0;
      din_q       <= '0;
      ram_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef DMEM_CTRL_BYTE_ACCESS_EN
      byte_q      <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      lo_q        <= lo_d;
      ram_addr_q  <= ram_addr_d;
      din_q       <= din_d;
      ram_we_q    <= ram_we_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef DMEM_CTRL_BYTE_ACCESS_EN
      byte_q      <= byte_d;
`endif
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = din_q;
  assign bus.ram_we    = ram_we_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with a behavioural byte RAM (sync write, 1-cycle read).
module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_WIDTH(16), .DWIDTH(16)) bus ();
  dmem_ctrl #(.ADDR_WIDTH(16), .DWIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0]  mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= bus.ram_we ? 8'hA5 : mem[bus.ram_addr];
  end

  int unsigned cyc = 0;
  int unsigned we_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.ram_we) we_cnt <= we_cnt + 1;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] rdata;
    int unsigned at_edge;
  } exp_t;
  exp_t q[$];

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rsp: rsp_valid at edge %0d, expected no response", cyc + 1);
      end else begin
        e = q.pop_front();
        check("rsp_edge", cyc + 1, e.at_edge);
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
      end
    end
  end

  task automatic preset(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Called and returns at a negedge; the accept edge is the following posedge.
  task automatic issue(input logic we, input logic size, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rdata,
                       input int unsigned lat, input int unsigned hold, input bit push,
                       output int unsigned acc_edge);
    int n = 0;
    acc_edge = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", bus.req_ready, 1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    acc_edge = cyc + 1;
    if (push) q.push_back('{exp_rdata, acc_edge + lat});
    @(negedge clk);
    for (int i = 0; i < int'(hold); i++) begin
      check("ready_busy", bus.req_ready, 0);
      bus.req_addr  = addr ^ 16'h5A5A ^ 16'(i);
      bus.req_wdata = ~wdata;
      bus.req_we    = ~we;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'h0BAD;
    bus.req_wdata = 16'hDEAD;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("rsp_timeout_pending", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a1, a2, a3, w0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    @(negedge clk);
    preset(16'h0010, 8'h00);
    preset(16'h0011, 8'h00);
    preset(16'hFFFF, 8'h00);
    preset(16'h0000, 8'h00);
    preset(16'h0021, 8'h00);
    preset(16'h0022, 8'h77);
    preset(16'h0040, 8'h11);
    preset(16'h0041, 8'h5A);

    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_din", bus.ram_din, 0);
    check("rst_ram_we", bus.ram_we, 0);
    rst = 1'b0;

    // Word store, then held-valid word load followed by an immediate reload
    w0 = we_cnt;
    issue(1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 3, 0, 1'b1, a1);
    drain();
    check("st_we_cycles", we_cnt - w0, 2);
    check("st_mem_lo", mem[16'h0010], 8'hEF);
    check("st_mem_hi", mem[16'h0011], 8'hBE);

    w0 = we_cnt;
    issue(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 4, 4, 1'b1, a1);
    check("ready_after_rsp", bus.req_ready, 1);
    issue(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 4, 0, 1'b1, a2);
    check("b2b_accept_edge", a2, a1 + 5);
    drain();
    check("ld_we_cycles", we_cnt - w0, 0);

    // Address wrap at the top of the space
    issue(1'b1, 1'b0, 16'hFFFF, 16'h1234, 16'hBEEF, 3, 0, 1'b1, a1);
    drain();
    check("wrap_mem_lo", mem[16'hFFFF], 8'h34);
    check("wrap_mem_hi", mem[16'h0000], 8'h12);
    issue(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 4, 0, 1'b1, a1);
    drain();

    // Byte-size requests
    w0 = we_cnt;
`ifdef DMEM_CTRL_BYTE_ACCESS_EN
    issue(1'b1, 1'b1, 16'h0021, 16'hAA55, 16'h1234, 2, 0, 1'b1, a1);
    drain();
    check("bst_we_cycles", we_cnt - w0, 1);
    check("bst_mem_a", mem[16'h0021], 8'h55);
    check("bst_mem_a1", mem[16'h0022], 8'h77);
    issue(1'b0, 1'b1, 16'h0021, 16'h0000, 16'h0055, 3, 0, 1'b1, a1);
    drain();
`else
    issue(1'b1, 1'b1, 16'h0021, 16'hAA55, 16'h1234, 3, 0, 1'b1, a1);
    drain();
    check("bst_we_cycles", we_cnt - w0, 2);
    check("bst_mem_a", mem[16'h0021], 8'h55);
    check("bst_mem_a1", mem[16'h0022], 8'hAA);
    issue(1'b0, 1'b1, 16'h0021, 16'h0000, 16'hAA55, 4, 0, 1'b1, a1);
    drain();
`endif

    // Reset while the high byte of a word store is being written
    issue(1'b1, 1'b0, 16'h0040, 16'hCAFE, 16'h0000, 3, 0, 1'b0, a3);
    @(negedge clk);
    check("abort_we_before_rst", bus.ram_we, 1);
    rst = 1'b1;
    #1;
    check("abort_we_async", bus.ram_we, 0);
    check("abort_ready_in_rst", bus.req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready_after", bus.req_ready, 1);
    repeat (6) @(negedge clk);
    check("abort_mem_lo", mem[16'h0040], 8'hFE);
    check("abort_mem_hi", mem[16'h0041], 8'h5A);
    check("abort_rdata_reset", bus.rsp_rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
